// File: rtl/sram_ms_pipe.sv
// Single-port SRAM behind analog-coded ports: thresholded inputs, 0/FULL_SCALE outputs,
// byte-enabled writes, zero-fill sweep after reset and a READ_LATENCY-deep read pipeline.
module sram_ms_pipe #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 6,
  parameter int ANA_WIDTH     = 8,
  parameter int FULL_SCALE    = 255,
  parameter int THRESHOLD     = 128,
  parameter int READ_LATENCY  = 1,   // 1..4
  parameter int WRITE_MODE    = 0,   // 0 read-first, 1 write-first, 2 no-change
  parameter int INIT_ON_RESET = 1
) (
  input  logic [ANA_WIDTH-1:0]                  clk_a,
  input  logic [ANA_WIDTH-1:0]                  rst_n_a,
  input  logic [ANA_WIDTH-1:0]                  en_a,
  input  logic [ANA_WIDTH-1:0]                  we_a,
  input  logic [ANA_WIDTH*(DATA_WIDTH/8)-1:0]   be_a,
  input  logic [ANA_WIDTH*ADDR_WIDTH-1:0]       addr_a,
  input  logic [ANA_WIDTH*DATA_WIDTH-1:0]       din_a,
  output logic [ANA_WIDTH*DATA_WIDTH-1:0]       dout_a,
  output logic [ANA_WIDTH-1:0]                  dvalid_a,
  output logic [ANA_WIDTH-1:0]                  busy_a
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ANA_WIDTH:0]    THR_CODE  = (ANA_WIDTH + 1)'(THRESHOLD);
  localparam logic [ANA_WIDTH-1:0]  HI_CODE   = ANA_WIDTH'(FULL_SCALE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;
  localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;

  function automatic logic decode(input logic [ANA_WIDTH-1:0] code);
    return {1'b0, code} >= THR_CODE;
  endfunction

  // Decoded digital view of the analog inputs
  logic                  clk;
  logic                  rst_n;
  logic                  en;
  logic                  we;
  logic [NUM_BYTES-1:0]  be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;

  assign clk   = decode(clk_a);
  assign rst_n = decode(rst_n_a);
  assign en    = decode(en_a);
  assign we    = decode(we_a);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_be_dec
      assign be[gi] = decode(be_a[gi*ANA_WIDTH +: ANA_WIDTH]);
    end
    for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_addr_dec
      assign addr[gi] = decode(addr_a[gi*ANA_WIDTH +: ANA_WIDTH]);
    end
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_din_dec
      assign din[gi] = decode(din_a[gi*ANA_WIDTH +: ANA_WIDTH]);
    end
  endgenerate

  // Control FSM: zero-fill sweep, then normal accesses
  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic                  init_wr;
  logic                  acc_ok;
  logic                  wr_any;
  logic                  launch;
  logic [ADDR_WIDTH-1:0] ram_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= RESET_STATE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    init_wr    = 1'b0;
    acc_ok     = 1'b0;
    case (state_reg)
      ST_INIT: begin
        init_wr  = rst_n;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST_ADDR) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        acc_ok = rst_n & en;
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

  // No-change mode suppresses the launch on writes; reads always launch.
  assign wr_any   = acc_ok & we;
  assign launch   = acc_ok & (~we | (WRITE_MODE != 2));
  assign ram_addr = init_wr ? cnt_reg : addr;

  // One RAM bank per byte lane so byte enables map onto independent write ports.
  logic [DATA_WIDTH-1:0] ram_q;

  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] q_reg;
      logic       lane_we;
      logic [7:0] lane_wdata;

      assign lane_we    = init_wr | (wr_any & be[gi]);
      assign lane_wdata = init_wr ? 8'h00 : din[gi*8 +: 8];

      always_ff @(posedge clk) begin
        if (lane_we) begin
          mem[ram_addr] <= lane_wdata;
        end
        if (launch) begin
          q_reg <= ((WRITE_MODE == 1) && lane_we) ? lane_wdata : mem[ram_addr];
        end
      end

      assign ram_q[gi*8 +: 8] = q_reg;
    end
  endgenerate

  logic ram_valid_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_valid_reg <= 1'b0;
    end else begin
      ram_valid_reg <= launch;
    end
  end

  // Extra delay stages between the RAM output register and the output register
  logic [DATA_WIDTH-1:0] tail_data;
  logic                  tail_valid;

  generate
    if (READ_LATENCY <= 1) begin : g_nopipe
      assign tail_data  = ram_q;
      assign tail_valid = ram_valid_reg;
    end else begin : g_pipe
      logic [DATA_WIDTH-1:0] data_reg  [READ_LATENCY-1];
      logic                  valid_reg [READ_LATENCY-1];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < READ_LATENCY - 1; k++) begin
            valid_reg[k] <= 1'b0;
          end
        end else begin
          valid_reg[0] <= ram_valid_reg;
          for (int k = 1; k < READ_LATENCY - 1; k++) begin
            valid_reg[k] <= valid_reg[k-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        data_reg[0] <= ram_q;
        for (int k = 1; k < READ_LATENCY - 1; k++) begin
          data_reg[k] <= data_reg[k-1];
        end
      end

      assign tail_data  = data_reg[READ_LATENCY-2];
      assign tail_valid = valid_reg[READ_LATENCY-2];
    end
  endgenerate

  // Output register holds the last delivered word between strobes.
  logic [DATA_WIDTH-1:0] dout_reg;
  logic                  dvalid_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_reg   <= '0;
      dvalid_reg <= 1'b0;
    end else begin
      dvalid_reg <= tail_valid;
      if (tail_valid) begin
        dout_reg <= tail_data;
      end
    end
  end

  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_dout_enc
      assign dout_a[gi*ANA_WIDTH +: ANA_WIDTH] = dout_reg[gi] ? HI_CODE : '0;
    end
  endgenerate

  assign dvalid_a = dvalid_reg ? HI_CODE : '0;
  assign busy_a   = (state_reg == ST_INIT) ? HI_CODE : '0;

endmodule

// File: tb/tb_sram_ms_pipe.sv
// Three instances share one stimulus: (latency 1, read-first), (2, write-first), (3, no-change).
// Expected words are queued per instance with their due edge and compared on delivery.
module tb_sram_ms_pipe;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic [7:0] clk_a;
  assign clk_a = clk ? 8'd128 : 8'd127;
  always #5 clk = ~clk;

  logic [7:0]   rst_n_a, en_a, we_a;
  logic [15:0]  be_a;
  logic [47:0]  addr_a;
  logic [127:0] din_a;
  logic [127:0] dout_w   [NI];
  logic [7:0]   dvalid_w [NI];
  logic [7:0]   busy_w   [NI];

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_dut
      sram_ms_pipe #(
        .READ_LATENCY(gi + 1),
        .WRITE_MODE  (gi)
      ) u_dut (
        .clk_a   (clk_a),
        .rst_n_a (rst_n_a),
        .en_a    (en_a),
        .we_a    (we_a),
        .be_a    (be_a),
        .addr_a  (addr_a),
        .din_a   (din_a),
        .dout_a  (dout_w[gi]),
        .dvalid_a(dvalid_w[gi]),
        .busy_a  (busy_w[gi])
      );
    end
  endgenerate

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb [NI][$];
  logic [15:0] mm [64];
  logic [15:0] last_w [NI];
  int          n_chk = 0;
  int          n_err = 0;
  int          edge_cnt = 0;
  bit          rst_lvl = 1'b0;
  bit          busy_m = 1'b0;
  bit          mon_on = 1'b0;
  logic [5:0]  cnt_m = '0;

  function automatic logic [7:0] enc(input bit b);
    return b ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
  endfunction

  function automatic logic [127:0] expand(input logic [15:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = d[i] ? 8'd255 : 8'd0;
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  // One clock edge: advance the reference model, then check every instance.
  task automatic step();
    exp_t e;
    bit   ev;
    @(posedge clk);
    edge_cnt++;
    if (!rst_lvl) begin
      busy_m = 1'b1;
      cnt_m  = '0;
      mon_on = 1'b1;
      for (int i = 0; i < NI; i++) begin
        sb[i].delete();
        last_w[i] = 16'h0000;
      end
    end else if (busy_m) begin
      mm[cnt_m] = 16'h0000;
      if (cnt_m == 6'd63) busy_m = 1'b0;
      cnt_m = cnt_m + 6'd1;
    end
    @(negedge clk);
    if (mon_on) begin
      for (int i = 0; i < NI; i++) begin
        ev = 1'b0;
        if (sb[i].size() != 0) begin
          e = sb[i][0];
          if (e.due == edge_cnt) begin
            ev = 1'b1;
            last_w[i] = e.data;
            e = sb[i].pop_front();
          end
        end
        check_val($sformatf("dvalid%0d", i), 128'(dvalid_w[i]), 128'(ev ? 8'd255 : 8'd0));
        check_val($sformatf("dout%0d", i), dout_w[i], expand(last_w[i]));
        check_val($sformatf("busy%0d", i), 128'(busy_w[i]), 128'(busy_m ? 8'd255 : 8'd0));
      end
    end
  endtask

  task automatic access(input logic [7:0] en_code, input bit we, input bit [1:0] be,
                        input bit [5:0] addr, input bit [15:0] din);
    logic [15:0] old_w, merged;
    exp_t        e;
    en_a = en_code;
    we_a = enc(we);
    for (int i = 0; i < 2; i++) be_a[i*8 +: 8] = enc(be[i]);
    for (int i = 0; i < 6; i++) addr_a[i*8 +: 8] = enc(addr[i]);
    for (int i = 0; i < 16; i++) din_a[i*8 +: 8] = enc(din[i]);
    if (en_code >= 8'd128 && rst_lvl && !busy_m) begin
      old_w  = mm[addr];
      merged = {be[1] ? din[15:8] : old_w[15:8], be[0] ? din[7:0] : old_w[7:0]};
      for (int i = 0; i < NI; i++) begin
        e.due = edge_cnt + 1 + (i + 1);
        if (!we || i == 0) begin
          e.data = old_w;
          sb[i].push_back(e);
        end else if (i == 1) begin
          e.data = merged;
          sb[i].push_back(e);
        end
      end
      if (we) mm[addr] = merged;
    end
    $display("txn edge=%0d en=%0d we=%0d be=%b addr=%0d din=%h", edge_cnt + 1, en_code, we, be, addr, din);
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      en_a = enc(1'b0);
      we_a = enc(1'b0);
      step();
    end
  endtask

  task automatic reset(input int n, input logic [7:0] code);
    rst_n_a = code;
    rst_lvl = 1'b0;
    en_a    = enc(1'b0);
    for (int k = 0; k < n; k++) step();
    rst_n_a = enc(1'b1);
    rst_lvl = 1'b1;
  endtask

  // Counts samples with busy high from the last reset edge onward; writes are hammered meanwhile.
  task automatic sweep_len(input string tag);
    int n;
    n = (busy_w[0] == 8'd255) ? 1 : 0;
    for (int k = 0; k < 200; k++) begin
      if (busy_w[0] != 8'd255) break;
      access(8'd255, 1'b1, 2'b11, 6'($urandom_range(0, 63)), 16'($urandom));
      if (busy_w[0] == 8'd255) n++;
    end
    check_val(tag, 128'(n), 128'(64));
  endtask

  initial begin
    rst_n_a = 8'd0;
    en_a    = 8'd0;
    we_a    = 8'd0;
    be_a    = '0;
    addr_a  = '0;
    din_a   = '0;

    // T1: reset, sweep length, swept contents
    reset(2, 8'd0);
    sweep_len("init_sweep_len");
    access(8'd255, 1'b0, 2'b00, 6'd5, 16'h0);
    access(8'd255, 1'b0, 2'b00, 6'd63, 16'h0);
    idle(4);

    // T2: full write then immediate read of the same address
    access(8'd200, 1'b1, 2'b11, 6'd2, 16'hA5C3);
    access(8'd200, 1'b0, 2'b00, 6'd2, 16'h0);
    idle(4);

    // T3: low byte only
    access(8'd255, 1'b1, 2'b01, 6'd2, 16'h1234);
    access(8'd255, 1'b0, 2'b00, 6'd2, 16'h0);
    idle(4);

    // T4: write modes, including a write with no byte enabled
    access(8'd255, 1'b1, 2'b11, 6'd2, 16'h3C3C);
    idle(4);
    access(8'd255, 1'b1, 2'b00, 6'd2, 16'hFFFF);
    idle(4);
    access(8'd255, 1'b0, 2'b00, 6'd2, 16'h0);
    idle(4);

    // T5: prefill then stream four reads
    for (int a = 0; a < 4; a++) access(8'd255, 1'b1, 2'b11, 6'(a), 16'(16'h0011 * (a + 1)));
    for (int a = 0; a < 4; a++) access(8'd255, 1'b0, 2'b00, 6'(a), 16'h0);
    idle(5);

    // Enable threshold boundary
    access(8'd127, 1'b0, 2'b00, 6'd1, 16'h0);
    idle(4);
    access(8'd128, 1'b0, 2'b00, 6'd1, 16'h0);
    idle(4);

    // T6: reset with a read in flight, then reset mid-sweep at cnt 10
    access(8'd255, 1'b0, 2'b00, 6'd3, 16'h0);
    reset(1, 8'd127);
    idle(10);
    reset(1, 8'd0);
    sweep_len("restart_sweep_len");

    // Mixed random traffic over a small address window
    for (int k = 0; k < 60; k++) begin
      access(8'($urandom_range(0, 255)), 1'($urandom), 2'($urandom), 6'($urandom_range(0, 7)), 16'($urandom));
    end
    idle(6);
    for (int i = 0; i < NI; i++) check_val($sformatf("drained%0d", i), 128'(sb[i].size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
